lsu_mem_stage: RTL
==================

// Module: lsu_mem_stage
// PURPOSE
//  Load/store unit in the MEM pipeline stage, upstream of the data-memory controller (cache + backing memory).
//  Turns a RISC-V load/store (funct3, addr, rs2) into a held memory request: byte-select vector, lane-replicated write data.
//  Stalls the pipeline until the controller raises mem_ready.
//  Extracts and sign/zero-extends load data, then delivers it to write-back as a one-cycle result pulse.
// PARAMETERS
//  TIMEOUT  255  max cycles waiting in ACCESS before abandoning the request (8-bit counter; must be 1..255)
// PORTS
//  clk           in   1   clock
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   MEM-stage instruction valid
//  req_load      in   1   instruction is a load
//  req_store     in   1   instruction is a store (req_load && req_store is illegal)
//  req_funct3    in   3   RISC-V width/sign code
//  req_addr      in   32  effective address
//  req_wdata     in   32  rs2 value
//  req_rd        in   5   load destination register
//  stall         out  1   hold upstream pipeline
//  wb_valid      out  1   one-cycle load result pulse
//  wb_data       out  32  extended load data
//  wb_rd         out  5   destination of wb_data
//  mem_address   out  32  to controller address
//  mem_datain    out  32  to controller datain
//  mem_ren       out  1   to controller ren
//  mem_wen       out  1   to controller wen
//  mem_byte_sel  out  4   to controller byte_select_vector
//  mem_ready     in   1   controller memReady (combinational, may rise any cycle)
//  mem_dataout   in   32  controller dataout
//  err_timeout   out  1   one-cycle pulse on abandoned request
//  err_illegal   out  1   one-cycle pulse on bad funct3 (load 011/110/111, store 011..111)
//  misalign_exc  out  1   one-cycle misalignment pulse (see CONFIGURATION)
//  exc_addr      out  32  address of last error/exception, held until next one
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counter 0. Reset mid-op aborts instantly; mem_ren/mem_wen drop asynchronously.
//  FSM IDLE -> ACCESS -> (RESP | IDLE):
//   IDLE: req_valid && (load|store) && legal -> capture addr/wdata/funct3/rd/type, go ACCESS.
//    Illegal funct3 -> err_illegal pulse, exc_addr<=req_addr, stay IDLE, no access.
//    stall = req_valid && (req_load|req_store), combinational.
//   ACCESS: mem_ren/mem_wen driven from captured regs, stable until exit; stall=1; counter++.
//    mem_ready && load -> register extracted data, go RESP. mem_ready && store -> go IDLE.
//    counter==TIMEOUT-1 without ready -> err_timeout, exc_addr<=addr, go IDLE, no wb.
//   RESP: wb_valid=1, wb_data/wb_rd valid, stall=0, go IDLE. Requests arriving in RESP are not captured.
//  Latency: load 3 cycles minimum (IDLE, ACCESS, RESP); store 2 cycles minimum.
//  Requests while state!=IDLE are ignored; upstream holds them because stall=1.
//  Byte select, o=addr[1:0]:
//   SB: 4'b0001<<o, datain={4{b}}
//   SH: 4'b0011<<{addr[1],0}, datain={2{h}}
//   SW: 4'b1111, datain=rs2
//   Loads present the same mask.
//  Load extract: d = mem_dataout >> 8*o (halves: 16*addr[1]).
//   LB sext d[7:0]; LBU zext; LH sext d[15:0]; LHU zext; LW as-is.
//  mem_address = captured address with low bits forced aligned (word: [1:0]=0; half: [0]=0).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   Half with addr[0]=1, or word with addr[1:0]!=0 -> no access; misalign_exc pulses in the IDLE capture cycle.
//   exc_addr<=req_addr; stall=1 that cycle only.
//  Not defined: misaligned access silently aligned as above; misalign_exc tied 0.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum {IDLE,ACCESS,RESP}, TIMEOUT width.
//  Sub-module lsu_align (combinational): funct3+addr+wdata -> byte_sel/datain; funct3+addr+dataout -> wb_data.
// TESTING
//  LBU addr 0x103, mem_dataout 0xAB000000, ready after 2 ACCESS cycles -> wb_data 0x000000AB, wb_valid 1 cycle, stall 4 cycles.
//  LB same data -> wb_data 0xFFFFFFAB; LH addr 0x102, dataout 0x80010000 -> 0xFFFF8001.
//  SH addr 0x202, rs2 0x1234ABCD -> byte_sel 4'b1100, datain 0xABCDABCD, mem_wen held until ready, no wb_valid.
//  mem_ready never rises, TIMEOUT=4 -> err_timeout after 4 ACCESS cycles, exc_addr=addr, back to IDLE.
//  LW addr 0x101: macro on -> misalign_exc, no mem_ren; macro off -> mem_address 0x100, normal load.
//  Reset asserted mid-ACCESS -> mem_ren 0 same cycle, stall 0, state IDLE; funct3 111 load -> err_illegal only.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 codes, FSM states, counter width.
// Legality/misalignment helpers are used by the MEM-stage LSU.
package lsu_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic logic f3_legal(
    input logic       is_load,
    input logic [2:0] f3
  );
    if (is_load)
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return (f3[1:0] == 2'b01 && off[0]) ||
           (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/replicated data and load
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] dataout,
  output logic [3:0]  byte_sel,
  output logic [31:0] datain,
  output logic [31:0] ldata
);

  logic       is_b;
  logic       is_h;
  logic       sx;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign is_b = funct3[1:0] == 2'b00;
  assign is_h = funct3[1:0] == 2'b01;
  assign sx   = ~funct3[2];
  assign lb   = dataout[{off, 3'b000} +: 8];
  assign lh   = dataout[{off[1], 4'b0000} +: 16];

  always_comb begin
    byte_sel = 4'b1111;
    datain   = wdata;
    ldata    = dataout;
    unique case (1'b1)
      is_b: begin
        byte_sel = 4'b0001 << off;
        datain   = {4{wdata[7:0]}};
        ldata    = {{24{lb[7] & sx}}, lb};
      end
      is_h: begin
        byte_sel = 4'b0011 << {off[1], 1'b0};
        datain   = {2{wdata[15:0]}};
        ldata    = {{16{lh[15] & sx}}, lh};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: holds one request until mem_ready.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  mem_byte_sel,
  input  logic        mem_ready,
  input  logic [31:0] mem_dataout,
  output logic        err_timeout,
  output logic        err_illegal,
  output logic        misalign_exc,
  output logic [31:0] exc_addr
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t state;
  state_t state_d;

  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             load_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      wb_data_q;
  logic [31:0]      exc_addr_q;

  logic [3:0]  sel;
  logic [31:0] din;
  logic [31:0] ldata;
  logic [1:0]  lo;
  logic        in_access;
  logic        is_req;
  logic        legal;
  logic        misal;
  logic        capture;
  logic        timeout;
  logic        ld_done;

  lsu_align u_align (
    .funct3   (f3_q),
    .off      (addr_q[1:0]),
    .wdata    (wdata_q),
    .dataout  (mem_dataout),
    .byte_sel (sel),
    .datain   (din),
    .ldata    (ldata)
  );

  assign is_req = req_valid && (req_load || req_store);
  assign legal  = f3_legal(req_load, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = legal &&
    f3_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d      = state;
    capture      = 1'b0;
    timeout      = 1'b0;
    ld_done      = 1'b0;
    stall        = 1'b0;
    err_illegal  = 1'b0;
    misalign_exc = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by reset so no pulse escapes while held in reset.
        stall = is_req && !reset;
        if (is_req && !reset) begin
          if (!legal) begin
            err_illegal = 1'b1;
          end else if (misal) begin
            misalign_exc = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ready) begin
          ld_done = load_q;
          state_d = load_q ? RESP : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lo = addr_q[1:0];
    if (f3_q[1:0] == 2'b10)
      lo = 2'b00;
    else if (f3_q[1:0] == 2'b01)
      lo[0] = 1'b0;
  end

  assign in_access    = state == ACCESS;
  assign mem_ren      = in_access && load_q;
  assign mem_wen      = in_access && !load_q;
  assign mem_address  = in_access ? {addr_q[31:2], lo} : '0;
  assign mem_datain   = in_access ? din : '0;
  assign mem_byte_sel = in_access ? sel : '0;
  assign err_timeout  = timeout;
  assign wb_valid     = state == RESP;
  assign wb_data      = wb_data_q;
  assign wb_rd        = rd_q;
  assign exc_addr     = exc_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      load_q     <= 1'b0;
      cnt_q      <= '0;
      wb_data_q  <= '0;
      exc_addr_q <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        rd_q    <= req_rd;
        load_q  <= req_load;
      end
      if (capture)
        cnt_q <= '0;
      else if (in_access)
        cnt_q <= cnt_q + CNT_W'(1);
      if (ld_done)
        wb_data_q <= ldata;
      if (err_illegal || misalign_exc)
        exc_addr_q <= req_addr;
      else if (timeout)
        exc_addr_q <= addr_q;
    end
  end

endmodule
